// File: rtl/stdy_guide.sv
// stdy_guide: study-mode song controller.
// Shows the goal note, judges key presses, scores hits and misses.
module stdy_guide #(
  parameter int NOTE_KEYS   = 7,
  parameter int LENGTH_KEYS = 4,
  parameter int OCT_BITS    = 3,
  parameter int STEP_BITS   = 8,
  parameter int SCORE_BITS  = 8,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRY   = 3,
  localparam int NW = $clog2(NOTE_KEYS+1),
  localparam int LW = $clog2(LENGTH_KEYS+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   mode,
  input  logic [NOTE_KEYS-1:0]   note_key,
  input  logic [LENGTH_KEYS-1:0] length_key,
  input  logic [OCT_BITS-1:0]    octave,
  input  logic [STEP_BITS-1:0]   track_last,
  input  logic [NW-1:0]          goal_note,
  input  logic [LW-1:0]          goal_length,
  input  logic [OCT_BITS-1:0]    goal_octave,
  output logic [STEP_BITS-1:0]   step,
  output logic [NOTE_KEYS-1:0]   note_led,
  output logic [LENGTH_KEYS-1:0] length_led,
  output logic                   play_req,
  input  logic                   play_done,
  output logic                   result_ok,
  output logic                   result_bad,
  output logic [SCORE_BITS-1:0]  hit_cnt,
  output logic [SCORE_BITS-1:0]  miss_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam int RW = $clog2(MAX_RETRY+1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_JMISS,
    S_REL, S_ADVCHK, S_ADV, S_DONE
  } state_t;

  state_t state, nxt;

  logic [RW-1:0]       retry_q, retry_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NW-1:0]       gn_q, gn_d;
  logic [LW-1:0]       gl_q, gl_d;
  logic [OCT_BITS-1:0] go_q, go_d;
  logic                ok_q, ok_d;
  logic                any_q;

  logic [STEP_BITS-1:0]   step_d;
  logic [SCORE_BITS-1:0]  hit_d, miss_d;
  logic [NOTE_KEYS-1:0]   nled_d;
  logic [LENGTH_KEYS-1:0] lled_d;
  logic req_d, rok_d, rbad_d, show;

  function automatic logic [NOTE_KEYS-1:0] oh_note(
    input logic [NW-1:0] g
  );
    oh_note = '0;
    for (int i = 0; i < NOTE_KEYS; i++)
      oh_note[i] = (g == NW'(i+1));
  endfunction

  function automatic logic [LENGTH_KEYS-1:0] oh_len(
    input logic [LW-1:0] g
  );
    oh_len = '0;
    for (int i = 0; i < LENGTH_KEYS; i++)
      oh_len[i] = (g == LW'(i+1));
  endfunction

  function automatic logic [SCORE_BITS-1:0] sat(
    input logic [SCORE_BITS-1:0] c
  );
    sat = (&c) ? c : c + SCORE_BITS'(1);
  endfunction

  logic any_key, key_edge, correct;

  assign any_key  = (|note_key) | (|length_key);
  assign key_edge = any_key & ~any_q;
  assign correct  = (note_key == oh_note(gn_q))
                 && (length_key == oh_len(gl_q))
                 && (octave == go_q);

  always_comb begin
    nxt     = state;
    step_d  = step;
    hit_d   = hit_cnt;
    miss_d  = miss_cnt;
    retry_d = retry_q;
    timer_d = '0;
    gn_d    = gn_q;
    gl_d    = gl_q;
    go_d    = go_q;
    ok_d    = ok_q;
    req_d   = 1'b0;
    rok_d   = 1'b0;
    rbad_d  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        nxt     = S_FETCH;
        step_d  = '0;
        hit_d   = '0;
        miss_d  = '0;
        retry_d = '0;
      end
      S_FETCH: begin
        gn_d = goal_note;
        gl_d = goal_length;
        go_d = goal_octave;
        nxt  = (goal_note == '0) ? S_ADV : S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (key_edge) begin
          nxt     = S_PLAY;
          timer_d = '0;
          req_d   = 1'b1;
          ok_d    = correct;
          if (correct) begin
            rok_d = 1'b1;
            hit_d = sat(hit_cnt);
          end else begin
            rbad_d = 1'b1;
            miss_d = sat(miss_cnt);
          end
        end else if (timer_q == TW'(TIMEOUT_CYC-1)) begin
          nxt     = S_JMISS;
          timer_d = '0;
          ok_d    = 1'b0;
          rbad_d  = 1'b1;
          miss_d  = sat(miss_cnt);
        end
      end
      S_PLAY:  if (play_done) nxt = S_REL;
      S_JMISS: nxt = S_ADVCHK;
      S_REL:   if (!any_key) nxt = S_ADVCHK;
      S_ADVCHK: begin
        if (!mode || ok_q || retry_q == RW'(MAX_RETRY-1)) begin
          nxt     = S_ADV;
          retry_d = '0;
        end else begin
          nxt     = S_WAIT;
          retry_d = retry_q + RW'(1);
        end
      end
      S_ADV: begin
        if (step == track_last) begin
          nxt = S_DONE;
        end else begin
          nxt    = S_FETCH;
          step_d = step + STEP_BITS'(1);
        end
      end
      S_DONE:  if (start) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // a dropped session parks in IDLE with scores held
    if (!en) begin
      nxt     = S_IDLE;
      step_d  = step;
      hit_d   = hit_cnt;
      miss_d  = miss_cnt;
      retry_d = retry_q;
      timer_d = '0;
      req_d   = 1'b0;
      rok_d   = 1'b0;
      rbad_d  = 1'b0;
    end
    show   = (nxt == S_WAIT) || (nxt == S_PLAY)
          || (nxt == S_REL);
    nled_d = show ? oh_note(gn_d) : '0;
    lled_d = show ? oh_len(gl_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      step       <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      gn_q       <= '0;
      gl_q       <= '0;
      go_q       <= '0;
      ok_q       <= 1'b0;
      any_q      <= 1'b0;
      note_led   <= '0;
      length_led <= '0;
      play_req   <= 1'b0;
      result_ok  <= 1'b0;
      result_bad <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt;
      step       <= step_d;
      hit_cnt    <= hit_d;
      miss_cnt   <= miss_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      gn_q       <= gn_d;
      gl_q       <= gl_d;
      go_q       <= go_d;
      ok_q       <= ok_d;
      any_q      <= any_key;
      note_led   <= nled_d;
      length_led <= lled_d;
      play_req   <= req_d;
      result_ok  <= rok_d;
      result_bad <= rbad_d;
      busy       <= (nxt != S_IDLE) && (nxt != S_DONE);
      done       <= (nxt == S_DONE);
    end
  end

endmodule
